// File: rtl/dvi_pkg.sv
// Shared types and helpers for the DVI timing / pattern generator.
package dvi_pkg;

  // Run-time pattern selection
  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_MOVE  = 2'd3
  } mode_e;

  // Output sequencing state
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Moving-bar geometry
  localparam int unsigned BarMoveW = 16;
  localparam int unsigned BarStep  = 4;

  // Total pixels per line or lines per frame
  function automatic int unsigned calc_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync_w, input int unsigned bp);
    return active + fp + sync_w + bp;
  endfunction

  // Counter width able to hold 0..total-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/dvi_timing_counter.sv
// Raster position counters with combinational sync/active/frame decode.
// Decodes are unregistered so the consumer can align them with its own pipeline.
module dvi_timing_counter
  import dvi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  localparam int unsigned HCntW   = cnt_width(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  localparam int unsigned VCntW   = cnt_width(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             en_i,
  output logic [HCntW-1:0] h_cnt_o,
  output logic [VCntW-1:0] v_cnt_o,
  output logic             active_o,
  output logic             hsync_act_o,
  output logic             vsync_act_o,
  output logic             first_o,
  output logic             line_end_o,
  output logic             last_o
);

  localparam int unsigned HTotal = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [HCntW-1:0] HLast = HCntW'(HTotal - 1);
  localparam logic [VCntW-1:0] VLast = VCntW'(VTotal - 1);
  localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
  localparam int unsigned VSyncStart = V_ACTIVE + V_FP;

  logic [HCntW-1:0] h_cnt_q, h_cnt_d;
  logic [VCntW-1:0] v_cnt_q, v_cnt_d;

  // Advance the raster position one pixel per enabled cycle
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (en_i) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + VCntW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HCntW'(1);
      end
    end
  end

  // Counter state
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Position decode; vsync follows v_cnt so it only moves at h_cnt = 0
  always_comb begin
    h_cnt_o     = h_cnt_q;
    v_cnt_o     = v_cnt_q;
    active_o    = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
    hsync_act_o = (32'(h_cnt_q) >= HSyncStart) && (32'(h_cnt_q) < HSyncStart + H_SYNC);
    vsync_act_o = (32'(v_cnt_q) >= VSyncStart) && (32'(v_cnt_q) < VSyncStart + V_SYNC);
    first_o     = (h_cnt_q == '0) && (v_cnt_q == '0);
    line_end_o  = (h_cnt_q == HLast);
    last_o      = (h_cnt_q == HLast) && (v_cnt_q == VLast);
  end

endmodule

// File: rtl/dvi_pattern_gen.sv
// DVI/VGA timing and test-pattern source with frame-aligned start/stop.
// Every output is registered one cycle after the counter position it describes.
module dvi_pattern_gen
  import dvi_pkg::*;
#(
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CHK_LOG2  = 5
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [1:0]         mode_i,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o,
  output logic               frame_start_o,
  output logic               busy_o
);

  localparam int unsigned HCntW = cnt_width(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int unsigned VCntW = cnt_width(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int unsigned BarW  = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int unsigned BarSubW = cnt_width(BarW);
  localparam logic [BarSubW-1:0] BarSubLast = BarSubW'(BarW - 1);
  localparam logic [COLOR_W-1:0] Full = '1;

  state_e state_q, state_d;
  logic   adv;
  logic [HCntW-1:0] h_cnt, bar_pos_q, bar_pos_d;
  logic [VCntW-1:0] v_cnt;
  logic active, hsync_act, vsync_act, first, line_end, last;
  logic [BarSubW-1:0] bar_sub_q, bar_sub_d;
  logic [2:0] bar_idx_q, bar_idx_d, bar_code;
  mode_e mode_q, mode_d, eff_mode;
  logic chk_white, in_bar;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d, busy_q, busy_d;

  dvi_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clock_i     (clock_i),
    .reset_ni    (reset_ni),
    .en_i        (adv),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .active_o    (active),
    .hsync_act_o (hsync_act),
    .vsync_act_o (vsync_act),
    .first_o     (first),
    .line_end_o  (line_end),
    .last_o      (last)
  );

  // FSM state register
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // FSM next state; start together with stop goes straight to a one-frame drain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = stop_i ? S_DRAIN : S_RUN;
      S_RUN:   if (stop_i) state_d = S_DRAIN;
      S_DRAIN: if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output: a pixel is produced on the start cycle and every cycle while busy
  always_comb begin
    adv = (state_q == S_IDLE) ? start_i : 1'b1;
  end

  // Mode latch, bar sub-counter and moving-bar position
  always_comb begin
    mode_d    = mode_q;
    bar_sub_d = bar_sub_q;
    bar_idx_d = bar_idx_q;
    bar_pos_d = bar_pos_q;
    if (adv) begin
      if (first) mode_d = mode_e'(mode_i);
      if (line_end) begin
        bar_sub_d = '0;
        bar_idx_d = '0;
      end else if (bar_sub_q == BarSubLast) begin
        bar_sub_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_sub_d = bar_sub_q + BarSubW'(1);
      end
      // Step once per frame so the new position is in place for the next frame's first pixel
      if (last) begin
        bar_pos_d = ((int'(bar_pos_q) + int'(BarStep)) > (int'(H_ACTIVE) - int'(BarMoveW))) ?
                    '0 : bar_pos_q + HCntW'(BarStep);
      end
    end
  end

  // Pattern registers
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mode_q    <= MODE_BARS;
      bar_sub_q <= '0;
      bar_idx_q <= '0;
      bar_pos_q <= '0;
    end else begin
      mode_q    <= mode_d;
      bar_sub_q <= bar_sub_d;
      bar_idx_q <= bar_idx_d;
      bar_pos_q <= bar_pos_d;
    end
  end

  // Pattern mux; the frame's first pixel already uses the newly sampled mode
  always_comb begin
    eff_mode  = first ? mode_e'(mode_i) : mode_q;
    bar_code  = 3'd7 - bar_idx_q;
    chk_white = (((32'(h_cnt) ^ 32'(v_cnt)) >> CHK_LOG2) & 32'd1) != 32'd0;
    in_bar    = (32'(h_cnt) >= 32'(bar_pos_q)) && (32'(h_cnt) < 32'(bar_pos_q) + BarMoveW);
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    unique case (eff_mode)
      MODE_BARS: begin
        pix_r = {COLOR_W{bar_code[1]}};
        pix_g = {COLOR_W{bar_code[2]}};
        pix_b = {COLOR_W{bar_code[0]}};
      end
      MODE_GRAD: begin
        pix_r = COLOR_W'(h_cnt);
        pix_g = COLOR_W'(h_cnt);
        pix_b = COLOR_W'(h_cnt);
      end
      MODE_CHECK: begin
        pix_r = chk_white ? Full : '0;
        pix_g = chk_white ? Full : '0;
        pix_b = chk_white ? Full : '0;
      end
      MODE_MOVE: begin
        pix_r = in_bar ? Full : '0;
        pix_g = in_bar ? Full : '0;
        pix_b = Full;
      end
      default: ;
    endcase
  end

  // Output next state: reset levels unless a pixel is being produced
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    hsync_d = ~HSYNC_POL;
    vsync_d = ~VSYNC_POL;
    de_d    = 1'b0;
    fs_d    = 1'b0;
    busy_d  = 1'b0;
    if (adv) begin
      busy_d  = 1'b1;
      de_d    = active;
      fs_d    = first;
      hsync_d = hsync_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = vsync_act ? VSYNC_POL : ~VSYNC_POL;
      if (active) begin
        red_d   = pix_r;
        green_d = pix_g;
        blue_d  = pix_b;
      end
    end
  end

  // Output registers
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
    end
  end

  assign red_o         = red_q;
  assign green_o       = green_q;
  assign blue_o        = blue_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign frame_start_o = fs_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_dvi_pattern_gen.sv
// Directed bench: A = 640-wide lines with short frames, B = tiny raster, C = B with hsync active-high.
module tb_dvi_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, stop_a, start_b, stop_b;
  logic [1:0] mode_a, mode_b;
  logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b, red_c, green_c, blue_c;
  logic       hs_a, vs_a, de_a, fs_a, busy_a;
  logic       hs_b, vs_b, de_b, fs_b, busy_b;
  logic       hs_c, vs_c, de_c, fs_c, busy_c;

  int checks = 0;
  int failures = 0;

  localparam int FrameA = 800 * 7;
  localparam int FrameB = 14 * 7;

  dvi_pattern_gen #(
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_dut_a (
    .clock_i (clk), .reset_ni (rst_n), .start_i (start_a), .stop_i (stop_a), .mode_i (mode_a),
    .red_o (red_a), .green_o (green_a), .blue_o (blue_a), .hsync_o (hs_a), .vsync_o (vs_a),
    .de_o (de_a), .frame_start_o (fs_a), .busy_o (busy_a)
  );

  dvi_pattern_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_dut_b (
    .clock_i (clk), .reset_ni (rst_n), .start_i (start_b), .stop_i (stop_b), .mode_i (mode_b),
    .red_o (red_b), .green_o (green_b), .blue_o (blue_b), .hsync_o (hs_b), .vsync_o (vs_b),
    .de_o (de_b), .frame_start_o (fs_b), .busy_o (busy_b)
  );

  dvi_pattern_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1), .HSYNC_POL (1'b1)
  ) u_dut_c (
    .clock_i (clk), .reset_ni (rst_n), .start_i (start_b), .stop_i (stop_b), .mode_i (mode_b),
    .red_o (red_c), .green_o (green_c), .blue_o (blue_c), .hsync_o (hs_c), .vsync_o (vs_c),
    .de_o (de_c), .frame_start_o (fs_c), .busy_o (busy_c)
  );

  initial begin
    #5_000_000;
    $display("FAIL timeout sim_time=%0t limit=5000000", $time);
    $fatal(1, "timeout");
  end

  // Bounded wait for instance A to go idle
  task automatic wait_idle_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 0; stop_a = 0; mode_a = 0;
    start_b = 0; stop_b = 0; mode_b = 0;
    repeat (3) @(negedge clk);
    checks++; if ({red_a, green_a, blue_a} !== 24'h0) begin failures++;
      $display("FAIL reset_rgb got=%h exp=000000", {red_a, green_a, blue_a}); end
    checks++; if (de_a !== 1'b0) begin failures++; $display("FAIL reset_de got=%b exp=0", de_a); end
    checks++; if (fs_a !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", fs_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (hs_a !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b exp=1", hs_a); end
    checks++; if (vs_a !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", vs_a); end
    checks++; if (hs_c !== 1'b0) begin failures++; $display("FAIL reset_hsync_pol1 got=%b exp=0", hs_c); end
    checks++; if (vs_c !== 1'b1) begin failures++; $display("FAIL reset_vsync_c got=%b exp=1", vs_c); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL idle_stop_busy got=%b exp=0", busy_a); end
    checks++; if (hs_a !== 1'b1) begin failures++; $display("FAIL idle_stop_hsync got=%b exp=1", hs_a); end
    checks++; if (hs_c !== 1'b0) begin failures++; $display("FAIL idle_hsync_pol1 got=%b exp=0", hs_c); end
  endtask

  // Tiny raster: full timing of frame 0, then stop in frame 1 and drain to idle
  task automatic test_timing_stop();
    int h, v;
    logic [2:0] c;
    logic ede;
    logic [23:0] ergb;
    mode_b = 2'd0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int p = 0; p < 2 * FrameB + 8; p++) begin
      h = p % 14;
      v = (p / 14) % 7;
      stop_b = (p == FrameB + 20);
      if (p < 2 * FrameB) begin
        ede  = (h < 8) && (v < 4);
        c    = 3'(7 - h);
        ergb = ede ? {{8{c[1]}}, {8{c[2]}}, {8{c[0]}}} : 24'h0;
        checks++; if (de_b !== ede) begin failures++;
          $display("FAIL tim_de p=%0d got=%b exp=%b", p, de_b, ede); end
        checks++; if (hs_b !== !(h >= 10 && h < 12)) begin failures++;
          $display("FAIL tim_hsync p=%0d got=%b exp=%b", p, hs_b, !(h >= 10 && h < 12)); end
        checks++; if (hs_c !== (h >= 10 && h < 12)) begin failures++;
          $display("FAIL tim_hsync_pol1 p=%0d got=%b exp=%b", p, hs_c, (h >= 10 && h < 12)); end
        checks++; if (vs_b !== (v != 5)) begin failures++;
          $display("FAIL tim_vsync p=%0d got=%b exp=%b", p, vs_b, (v != 5)); end
        checks++; if (fs_b !== (h == 0 && v == 0)) begin failures++;
          $display("FAIL tim_fs p=%0d got=%b exp=%b", p, fs_b, (h == 0 && v == 0)); end
        checks++; if ({red_b, green_b, blue_b} !== ergb) begin failures++;
          $display("FAIL tim_rgb p=%0d got=%h exp=%h", p, {red_b, green_b, blue_b}, ergb); end
        checks++; if (busy_b !== 1'b1) begin failures++;
          $display("FAIL drain_busy p=%0d got=%b exp=1", p, busy_b); end
      end else begin
        checks++; if (busy_b !== 1'b0) begin failures++;
          $display("FAIL after_drain_busy p=%0d got=%b exp=0", p, busy_b); end
        checks++; if ({de_b, fs_b, hs_b, vs_b} !== 4'b0011) begin failures++;
          $display("FAIL after_drain_ctl p=%0d got=%b exp=0011", p, {de_b, fs_b, hs_b, vs_b}); end
        checks++; if ({red_b, green_b, blue_b} !== 24'h0) begin failures++;
          $display("FAIL after_drain_rgb p=%0d got=%h exp=000000", p, {red_b, green_b, blue_b}); end
      end
      @(negedge clk);
    end
    stop_b = 1'b0;
  endtask

  // start and stop together in idle: exactly one frame, then idle
  task automatic test_back_to_back();
    start_b = 1'b1;
    stop_b  = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    stop_b  = 1'b0;
    for (int p = 0; p < FrameB + 4; p++) begin
      checks++; if (busy_b !== (p < FrameB)) begin failures++;
        $display("FAIL startstop_busy p=%0d got=%b exp=%b", p, busy_b, (p < FrameB)); end
      if (p == 0) begin
        checks++; if (fs_b !== 1'b1) begin failures++;
          $display("FAIL startstop_fs got=%b exp=1", fs_b); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bars();
    int bar;
    logic [2:0] c;
    logic [23:0] ergb;
    bit ok;
    mode_a = 2'd0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int h = 0; h < 800; h++) begin
      bar  = h / 80;
      c    = 3'(7 - bar);
      ergb = (h < 640) ? {{8{c[1]}}, {8{c[2]}}, {8{c[0]}}} : 24'h0;
      checks++; if ({red_a, green_a, blue_a} !== ergb) begin failures++;
        $display("FAIL bars_rgb x=%0d got=%h exp=%h", h, {red_a, green_a, blue_a}, ergb); end
      @(negedge clk);
    end
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    wait_idle_a(FrameA + 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bars_drain busy=%b exp=0", busy_a); end
  endtask

  task automatic test_mode_switch();
    int h, v, f;
    logic [23:0] ergb;
    bit ok;
    mode_a = 2'd1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int p = 0; p < FrameA + 100; p++) begin
      h = p % 800;
      v = (p / 800) % 7;
      f = p / FrameA;
      if (p == 2 * 800) mode_a = 2'd2;
      if (f == 0 && (v == 0 || v == 3) && (h == 5 || h == 300 || h == 639 || h == 700)) begin
        ergb = (h < 640) ? {3{8'(h)}} : 24'h0;
        checks++; if ({red_a, green_a, blue_a} !== ergb) begin failures++;
          $display("FAIL grad_rgb x=%0d y=%0d got=%h exp=%h", h, v, {red_a, green_a, blue_a}, ergb); end
      end
      if (f == 1 && v == 0 && (h == 0 || h == 32 || h == 64 || h == 96)) begin
        ergb = ((h / 32) % 2 == 1) ? 24'hFFFFFF : 24'h0;
        checks++; if ({red_a, green_a, blue_a} !== ergb) begin failures++;
          $display("FAIL check_rgb x=%0d got=%h exp=%h", h, {red_a, green_a, blue_a}, ergb); end
      end
      @(negedge clk);
    end
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    wait_idle_a(FrameA + 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL switch_drain busy=%b exp=0", busy_a); end
  endtask

  task automatic test_reset_midline();
    mode_a = 2'd1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (299) @(negedge clk);
    checks++; if ({red_a, green_a, blue_a} !== {3{8'd43}}) begin failures++;
      $display("FAIL pre_reset_rgb got=%h exp=2b2b2b", {red_a, green_a, blue_a}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({red_a, green_a, blue_a} !== 24'h0) begin failures++;
      $display("FAIL async_reset_rgb got=%h exp=000000", {red_a, green_a, blue_a}); end
    checks++; if ({de_a, busy_a, hs_a, vs_a} !== 4'b0011) begin failures++;
      $display("FAIL async_reset_ctl got=%b exp=0011", {de_a, busy_a, hs_a, vs_a}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++; if ({fs_a, busy_a, de_a} !== 3'b111) begin failures++;
      $display("FAIL restart_first got=%b exp=111", {fs_a, busy_a, de_a}); end
    @(negedge clk);
    checks++; if (fs_a !== 1'b0) begin failures++; $display("FAIL restart_fs_pulse got=%b exp=0", fs_a); end
    checks++; if ({red_a, green_a, blue_a} !== 24'h010101) begin failures++;
      $display("FAIL restart_rgb got=%h exp=010101", {red_a, green_a, blue_a}); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_moving();
    int h, v, f, bp;
    mode_a = 2'd3;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int p = 0; p <= 3 * FrameA; p++) begin
      h  = p % 800;
      v  = (p / 800) % 7;
      f  = p / FrameA;
      bp = 4 * f;
      stop_a = (p == 2 * FrameA + 10);
      if (f < 3 && v == 0) begin
        if (h == bp || h == bp + 15) begin
          checks++; if ({red_a, green_a, blue_a} !== 24'hFFFFFF) begin failures++;
            $display("FAIL move_white f=%0d x=%0d got=%h exp=ffffff", f, h, {red_a, green_a, blue_a});
          end
        end
        if (h == bp + 16 || (f > 0 && h == bp - 1)) begin
          checks++; if ({red_a, green_a, blue_a} !== 24'h0000FF) begin failures++;
            $display("FAIL move_blue f=%0d x=%0d got=%h exp=0000ff", f, h, {red_a, green_a, blue_a});
          end
        end
      end
      if (p == 3 * FrameA) begin
        checks++; if ({busy_a, de_a} !== 2'b00) begin failures++;
          $display("FAIL move_drain got=%b exp=00", {busy_a, de_a}); end
      end
      @(negedge clk);
    end
    stop_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timing_stop();
    test_back_to_back();
    test_bars();
    test_mode_switch();
    test_reset_midline();
    test_moving();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
